// File: rtl/iir_biquad_lowpass_seq_if.sv
// Sample-stream bundle for the sequential biquad lowpass: input handshake, history flush and output strobe.
// With IIR_SAT_FLAG_EN defined the bundle also carries the sat_flag output.
interface iir_biquad_lowpass_seq_if #(
  parameter int unsigned word_size_in  = 8,
  parameter int unsigned word_size_out = 8
);
  logic signed [word_size_in-1:0]  Data_in;
  logic                            in_valid;
  logic                            in_ready;
  logic                            clear;
  logic signed [word_size_out-1:0] Data_out;
  logic                            out_valid;
`ifdef IIR_SAT_FLAG_EN
  logic                            sat_flag;
`endif

  // Filter side
  modport slave (
    input  Data_in, in_valid, clear,
    output in_ready, Data_out, out_valid
`ifdef IIR_SAT_FLAG_EN
    , output sat_flag
`endif
  );

  // Stream source / sink side
  modport master (
    output Data_in, in_valid, clear,
    input  in_ready, Data_out, out_valid
`ifdef IIR_SAT_FLAG_EN
    , input sat_flag
`endif
  );
endinterface

// File: rtl/iir_biquad_lowpass_seq.sv
// Direct-form-I biquad lowpass with one shared multiplier stepped over five taps per sample.
// Optional feature macro IIR_SAT_FLAG_EN adds a sat_flag strobe when an output was clamped.
module iir_biquad_lowpass_seq #(
  parameter int unsigned word_size_in  = 8,
  parameter int unsigned word_size_out = 8,
  parameter int unsigned coef_size     = 8,
  parameter int unsigned frac_bits     = 6,
  parameter int unsigned acc_size      = word_size_in + coef_size + 3,
  parameter logic signed [coef_size-1:0] b0 = 8'sd4,
  parameter logic signed [coef_size-1:0] b1 = 8'sd8,
  parameter logic signed [coef_size-1:0] b2 = 8'sd4,
  parameter logic signed [coef_size-1:0] a1 = -8'sd64,
  parameter logic signed [coef_size-1:0] a2 = 8'sd16
) (
  input logic                    clock,
  input logic                    reset,
  iir_biquad_lowpass_seq_if.slave bus
);
  localparam int unsigned prod_size = coef_size + word_size_in;
  localparam int unsigned tap_w     = 3;
  localparam logic [tap_w-1:0] last_tap = tap_w'(4);
  localparam logic signed [acc_size-1:0] round_k = acc_size'(2 ** (frac_bits - 1));
  localparam logic signed [acc_size-1:0] max_k   = acc_size'(2 ** (word_size_out - 1) - 1);
  localparam logic signed [acc_size-1:0] min_k   = ~max_k;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  state_e                          state_q;
  logic [tap_w-1:0]                tap_q;
  logic signed [word_size_in-1:0]  x0_q, x1_q, x2_q;
  logic signed [word_size_out-1:0] y1_q, y2_q;
  logic signed [acc_size-1:0]      acc_q;
  logic signed [word_size_out-1:0] data_out_q;
  logic                            out_valid_q;
  logic                            ready_q;
`ifdef IIR_SAT_FLAG_EN
  logic                            sat_q;
`endif

  logic signed [coef_size-1:0]     coef_c;
  logic signed [word_size_in-1:0]  samp_c;
  logic signed [prod_size-1:0]     prod_c;
  logic signed [acc_size-1:0]      acc_next_c;
  logic signed [acc_size-1:0]      rounded_c;
  logic signed [word_size_out-1:0] sat_c;

  // Tap select, shared multiply, accumulate; feedback taps are subtracted
  always_comb begin
    coef_c = '0;
    samp_c = '0;
    unique case (tap_q)
      3'd0:    begin coef_c = b0; samp_c = x0_q; end
      3'd1:    begin coef_c = b1; samp_c = x1_q; end
      3'd2:    begin coef_c = b2; samp_c = x2_q; end
      3'd3:    begin coef_c = a1; samp_c = word_size_in'(y1_q); end
      3'd4:    begin coef_c = a2; samp_c = word_size_in'(y2_q); end
      default: begin coef_c = '0; samp_c = '0; end
    endcase
    prod_c     = prod_size'(coef_c) * prod_size'(samp_c);
    acc_next_c = (tap_q >= tap_w'(3)) ? acc_q - acc_size'(prod_c)
                                      : acc_q + acc_size'(prod_c);
  end

  // Round half-up then clamp to the output range
  always_comb begin
    rounded_c = (acc_q + round_k) >>> frac_bits;
    if (rounded_c > max_k)      sat_c = word_size_out'(max_k);
    else if (rounded_c < min_k) sat_c = word_size_out'(min_k);
    else                        sat_c = word_size_out'(rounded_c);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b0;
`ifdef IIR_SAT_FLAG_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
`ifdef IIR_SAT_FLAG_EN
      sat_q       <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (bus.clear) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
          end else if (bus.in_valid && ready_q) begin
            x0_q    <= bus.Data_in;
            acc_q   <= '0;
            tap_q   <= '0;
            ready_q <= 1'b0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_next_c;
          if (tap_q == last_tap) state_q <= DONE;
          else                   tap_q   <= tap_q + tap_w'(1);
        end
        DONE: begin
          data_out_q  <= sat_c;
          out_valid_q <= 1'b1;
`ifdef IIR_SAT_FLAG_EN
          sat_q       <= (rounded_c > max_k) || (rounded_c < min_k);
`endif
          x2_q    <= x1_q;
          x1_q    <= x0_q;
          y2_q    <= y1_q;
          y1_q    <= sat_c;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Flush request masks ready the same cycle so a simultaneous sample is refused
  assign bus.in_ready  = ready_q & ~bus.clear;
  assign bus.Data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
`ifdef IIR_SAT_FLAG_EN
  assign bus.sat_flag  = sat_q;
`endif
endmodule
